instr_fetch_unit: RTL and testbench

- Program sequencer directly upstream of the processor control unit.
- Owns the program counter (PC) and reads 16-bit instructions from a synchronous-read instruction ROM.
- Presents a stable instruction word and the `run` enable to the control unit, then waits for the control unit's one-cycle `done` pulse before advancing to the next instruction.
- Supports free-run, single-step and HALT (instruction format 2'b11).

---
 rtl/instr_fetch_unit.sv | 102 ++++++++++
 tb/tb_instr_fetch_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer: owns the PC, reads a synchronous ROM and hands one
// instruction at a time to the control unit, advancing on its done pulse.
module instr_fetch_unit #(
   parameter int unsigned ADDR_WIDTH  = 8,
   parameter int unsigned RESET_PC    = 0,
   parameter int unsigned COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   single_step,
   input  logic                   done,
   input  logic [15:0]            mem_rdata,
   output logic [ADDR_WIDTH-1:0]  mem_addr,
   output logic                   mem_rd_en,
   output logic [15:0]            instruction,
   output logic                   run,
   output logic [ADDR_WIDTH-1:0]  pc,
   output logic                   busy,
   output logic                   halted,
   output logic [COUNT_WIDTH-1:0] instr_count
);

   localparam int unsigned INSTR_WIDTH = 16;
   localparam logic [1:0]  HALT_OP     = 2'b11;
   localparam logic [ADDR_WIDTH-1:0] PC_INIT = ADDR_WIDTH'(RESET_PC);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_WAIT   = 3'd2,
      S_EXEC   = 3'd3,
      S_HALTED = 3'd4
   } state_t;

   state_t                 state;
   state_t                 state_next;
   logic [ADDR_WIDTH-1:0]  pc_next;
   logic [COUNT_WIDTH-1:0] count_next;
   logic [INSTR_WIDTH-1:0] instr_next;

   assign mem_addr = pc;

   // Next-state and datapath update; the instruction word only moves at the WAIT exit.
   always_comb begin
      state_next = state;
      pc_next    = pc;
      count_next = instr_count;
      instr_next = instruction;
      case (state)
         S_IDLE: begin
            if (start) state_next = S_FETCH;
         end
         S_FETCH: begin
            state_next = S_WAIT;
         end
         S_WAIT: begin
            instr_next = mem_rdata;
            if (mem_rdata[1:0] == HALT_OP) state_next = S_HALTED;
            else                           state_next = S_EXEC;
         end
         S_EXEC: begin
            if (done) begin
               pc_next    = pc + ADDR_WIDTH'(1);
               count_next = instr_count + COUNT_WIDTH'(1);
               state_next = single_step ? S_IDLE : S_FETCH;
            end
         end
         S_HALTED: begin
            state_next = S_HALTED;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Status outputs are registered from the next state so they track the state register exactly.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         pc          <= PC_INIT;
         instr_count <= '0;
         instruction <= '0;
         mem_rd_en   <= 1'b0;
         run         <= 1'b0;
         busy        <= 1'b0;
         halted      <= 1'b0;
      end else begin
         state       <= state_next;
         pc          <= pc_next;
         instr_count <= count_next;
         instruction <= instr_next;
         mem_rd_en   <= (state_next == S_FETCH);
         run         <= (state_next == S_EXEC);
         busy        <= (state_next == S_FETCH) || (state_next == S_WAIT) ||
                        (state_next == S_EXEC);
         halted      <= (state_next == S_HALTED);
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: ROM models, a scoreboard of expected
// instruction words, and immediate-assertion checks at each step.
module tb_instr_fetch_unit;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic single_step = 1'b0;

   // main instance (8-bit PC)
   logic        start_a = 1'b0;
   logic        done_a = 1'b0;
   logic [15:0] rdata_a = 16'h0;
   logic [7:0]  addr_a;
   logic        rd_en_a;
   logic [15:0] instr_a;
   logic        run_a;
   logic [7:0]  pc_a;
   logic        busy_a;
   logic        halted_a;
   logic [15:0] count_a;

   // wrap instance (4-bit PC starting at 15)
   logic        start_w = 1'b0;
   logic        done_w = 1'b0;
   logic [15:0] rdata_w = 16'h0;
   logic [3:0]  addr_w;
   logic        rd_en_w;
   logic [15:0] instr_w;
   logic        run_w;
   logic [3:0]  pc_w;
   logic        busy_w;
   logic        halted_w;
   logic [15:0] count_w;

   logic [15:0] rom_a [256];
   logic [15:0] rom_w [16];
   logic [15:0] exp_q [$];

   int vectors = 0;
   int miscompares = 0;

   instr_fetch_unit #(.ADDR_WIDTH(8), .RESET_PC(0), .COUNT_WIDTH(16)) dut_a (
      .clk(clk), .reset(reset), .start(start_a), .single_step(single_step),
      .done(done_a), .mem_rdata(rdata_a), .mem_addr(addr_a), .mem_rd_en(rd_en_a),
      .instruction(instr_a), .run(run_a), .pc(pc_a), .busy(busy_a),
      .halted(halted_a), .instr_count(count_a)
   );

   instr_fetch_unit #(.ADDR_WIDTH(4), .RESET_PC(15), .COUNT_WIDTH(16)) dut_w (
      .clk(clk), .reset(reset), .start(start_w), .single_step(single_step),
      .done(done_w), .mem_rdata(rdata_w), .mem_addr(addr_w), .mem_rd_en(rd_en_w),
      .instruction(instr_w), .run(run_w), .pc(pc_w), .busy(busy_w),
      .halted(halted_w), .instr_count(count_w)
   );

   always #5 clk = ~clk;

   // synchronous-read ROMs: data valid the cycle after the read strobe
   always @(posedge clk) begin
      if (rd_en_a) rdata_a <= rom_a[addr_a];
      if (rd_en_w) rdata_w <= rom_w[addr_w];
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
   endtask

   // Wait for run, check the word against the scoreboard, hold 3 cycles, then answer done.
   task automatic run_instr(input string tag);
      logic [15:0] exp;
      for (int i = 0; i < 20 && !run_a; i++) tick();
      chk({tag, "_run"}, 32'(run_a), 32'd1);
      chk({tag, "_sb"}, 32'(exp_q.size() > 0), 32'd1);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
      chk({tag, "_instr"}, 32'(instr_a), 32'(exp));
      repeat (3) tick();
      chk({tag, "_hold"}, 32'({run_a, instr_a}), 32'({1'b1, exp}));
      done_a = 1'b1;
      tick();
      done_a = 1'b0;
   endtask

   initial begin
      bit bad;
      for (int i = 0; i < 256; i++) rom_a[i] = 16'h0003;
      for (int i = 0; i < 16; i++)  rom_w[i] = 16'h0003;
      rom_w[15] = 16'h0001;

      // reset then idle
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      chk("rst_pc", 32'(pc_a), 32'd0);
      chk("rst_run", 32'(run_a), 32'd0);
      chk("rst_rd_en", 32'(rd_en_a), 32'd0);
      chk("rst_instr", 32'(instr_a), 32'd0);
      chk("rst_busy_halted", 32'({busy_a, halted_a}), 32'd0);
      chk("rst_count", 32'(count_a), 32'd0);
      chk("rst_pc_w", 32'(pc_w), 32'd15);
      bad = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (rd_en_a !== 1'b0) bad = 1'b1;
      end
      chk("idle_no_rd_en", 32'(bad), 32'd0);

      // free-run with spurious done and start during a fetch/exec
      rom_a[0] = 16'h2001;
      rom_a[1] = 16'h4000;
      rom_a[2] = 16'h0003;
      exp_q.push_back(16'h2001);
      exp_q.push_back(16'h4000);
      pulse_start();
      chk("fr_fetch", 32'({rd_en_a, busy_a, run_a, addr_a}), 32'({1'b1, 1'b1, 1'b0, 8'd0}));
      tick();
      chk("fr_wait", 32'({rd_en_a, run_a}), 32'd0);
      tick();
      chk("fr_latency_run", 32'(run_a), 32'd1);
      run_instr("fr_i0");
      chk("fr_turn_fetch", 32'({run_a, rd_en_a, addr_a}), 32'({1'b0, 1'b1, 8'd1}));
      chk("fr_count1", 32'(count_a), 32'd1);
      done_a = 1'b1;
      tick();
      tick();
      done_a = 1'b0;
      chk("spurious_done_pc", 32'({run_a, pc_a}), 32'({1'b1, 8'd1}));
      chk("spurious_done_count", 32'(count_a), 32'd1);
      start_a = 1'b1;
      run_instr("fr_i1");
      start_a = 1'b0;
      chk("fr_fetch2", 32'({rd_en_a, addr_a}), 32'({1'b1, 8'd2}));
      tick();
      tick();
      chk("fr_halted", 32'({halted_a, run_a, busy_a}), 32'({1'b1, 1'b0, 1'b0}));
      chk("fr_halt_pc", 32'(pc_a), 32'd2);
      chk("fr_halt_count", 32'(count_a), 32'd2);
      chk("fr_halt_instr", 32'(instr_a), 32'h0003);
      bad = 1'b0;
      start_a = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (halted_a !== 1'b1 || rd_en_a !== 1'b0 || run_a !== 1'b0) bad = 1'b1;
      end
      start_a = 1'b0;
      chk("halt_sticky", 32'(bad), 32'd0);

      // single-step
      reset = 1'b1;
      tick();
      reset = 1'b0;
      single_step = 1'b1;
      exp_q.push_back(16'h2001);
      exp_q.push_back(16'h4000);
      pulse_start();
      run_instr("ss_i0");
      chk("ss_idle", 32'({busy_a, run_a, pc_a}), 32'({1'b0, 1'b0, 8'd1}));
      chk("ss_count", 32'(count_a), 32'd1);
      bad = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (run_a !== 1'b0 || rd_en_a !== 1'b0) bad = 1'b1;
      end
      chk("ss_stays_idle", 32'(bad), 32'd0);
      pulse_start();
      chk("ss_fetch_addr1", 32'({rd_en_a, addr_a}), 32'({1'b1, 8'd1}));
      single_step = 1'b0;
      run_instr("ss_i1");
      chk("ss_clear_continues", 32'({rd_en_a, addr_a}), 32'({1'b1, 8'd2}));
      tick();
      tick();
      chk("ss_halted", 32'(halted_a), 32'd1);

      // reset in the middle of an instruction at pc 5
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 8; i++) rom_a[i] = 16'h1000 + 16'(i << 4);
      for (int i = 0; i < 6; i++) exp_q.push_back(16'h1000 + 16'(i << 4));
      pulse_start();
      for (int k = 0; k < 5; k++) run_instr("mx");
      for (int i = 0; i < 20 && !run_a; i++) tick();
      chk("mx_at_pc5", 32'({run_a, pc_a}), 32'({1'b1, 8'd5}));
      chk("mx_instr5", 32'(instr_a), 32'(exp_q.pop_front()));
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mx_rst_run_busy", 32'({run_a, busy_a, rd_en_a}), 32'd0);
      chk("mx_rst_pc", 32'(pc_a), 32'd0);
      chk("mx_rst_instr", 32'(instr_a), 32'd0);
      chk("mx_rst_count", 32'(count_a), 32'd0);

      // PC wrap on the 4-bit instance
      chk("wr_pc15", 32'(pc_w), 32'd15);
      exp_q.push_back(16'h0001);
      start_w = 1'b1;
      tick();
      start_w = 1'b0;
      chk("wr_fetch15", 32'({rd_en_w, addr_w}), 32'({1'b1, 4'd15}));
      tick();
      tick();
      chk("wr_run", 32'(run_w), 32'd1);
      chk("wr_instr", 32'(instr_w), 32'(exp_q.pop_front()));
      done_w = 1'b1;
      tick();
      done_w = 1'b0;
      chk("wr_wrapped", 32'({rd_en_w, pc_w, addr_w}), 32'({1'b1, 4'd0, 4'd0}));
      chk("wr_count", 32'(count_w), 32'd1);
      tick();
      tick();
      chk("wr_halted", 32'(halted_w), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
